// File: rtl/tcm_pkg.sv
// Shared constants for the test completion monitor: FSM encodings and default counter width.
// Pure declarations; no logic.
package tcm_pkg;
  localparam int CNT_W_DEF = 32;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PASS    = 2'd2;
  localparam logic [1:0] TIMEOUT = 2'd3;
endpackage

// File: rtl/tcm_slot.sv
// One completion slot: sticky done latch plus first-rise timestamp register.
// One-cycle latch latency; no backpressure (clr wins over capture).
module tcm_slot
  import tcm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             done_in,
  input  logic [CNT_W-1:0] cycles,
  output logic             done,
  output logic [CNT_W-1:0] ts
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      ts   <= '0;
    end else if (clr) begin
      done <= 1'b0;
      ts   <= '0;
    end else if (en && done_in && !done) begin
      // Only the first rise is recorded; later glitches low/high are ignored.
      done <= 1'b1;
      ts   <= cycles;
    end
  end

endmodule

// File: rtl/test_completion_monitor.sv
// Tracks per-group completion flags, timestamps first rises, and reports PASS or TIMEOUT.
// Status is registered (1-cycle after final flag); ts readout is combinational; no backpressure.
module test_completion_monitor
  import tcm_pkg::*;
#(
  parameter int N_GROUPS    = 6,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = 100000,
  localparam int SEL_W      = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_GROUPS-1:0] group_done,
  output logic [N_GROUPS-1:0] done_mask,
  output logic                busy,
  output logic                all_done,
  output logic                timed_out,
  output logic [CNT_W-1:0]    cycles,
  input  logic [SEL_W-1:0]    ts_sel,
  output logic [CNT_W-1:0]    ts_val,
  output logic                ts_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state;
  logic             in_run;
  logic             start_run;
  logic             all_now;
  logic [CNT_W-1:0] ts [N_GROUPS];

  assign in_run    = (state == RUN);
  assign start_run = start && !in_run;
  // Counting the flags still in flight lets PASS land on the same edge as the last latch.
  assign all_now   = &(done_mask | group_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cycles <= '0;
    end else if (in_run) begin
      if (cycles != CNT_MAX) cycles <= cycles + 1'b1;
      if (all_now)                     state <= PASS;
      else if (cycles == TIMEOUT_LAST) state <= TIMEOUT;
    end else if (start_run) begin
      state  <= RUN;
      cycles <= '0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_GROUPS; g++) begin : g_slot
      tcm_slot #(.CNT_W(CNT_W)) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (start_run),
        .en      (in_run),
        .done_in (group_done[g]),
        .cycles  (cycles),
        .done    (done_mask[g]),
        .ts      (ts[g])
      );
    end
  endgenerate

  assign busy      = (state == RUN);
  assign all_done  = (state == PASS);
  assign timed_out = (state == TIMEOUT);

  // Out-of-range selects fall through to zero/invalid.
  always_comb begin
    ts_val   = '0;
    ts_valid = 1'b0;
    for (int i = 0; i < N_GROUPS; i++) begin
      if (ts_sel == SEL_W'(i)) begin
        ts_val   = ts[i];
        ts_valid = done_mask[i];
      end
    end
  end

endmodule
